// File: rtl/axi_master_burst_writer.sv
// AXI4 write master: splits a beat-count request into INCR bursts fed from a FWFT FIFO.
// Optional macro AXI_WR_4K_SPLIT_EN additionally keeps every burst inside one 4 KB page.
module axi_master_burst_writer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int MAX_BURST  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     target_addr,
   input  logic [LEN_WIDTH-1:0]      target_beats,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   input  logic                      done_ack,
   input  logic [DATA_WIDTH-1:0]     fifo_rdata,
   input  logic                      fifo_rempty,
   output logic                      fifo_rpull,
   input  logic                      AWREADY,
   output logic                      AWVALID,
   output logic [ADDR_WIDTH-1:0]     AWADDR,
   output logic [7:0]                AWLEN,
   output logic [2:0]                AWSIZE,
   output logic [1:0]                AWBURST,
   input  logic                      WREADY,
   output logic                      WVALID,
   output logic [DATA_WIDTH-1:0]     WDATA,
   output logic [DATA_WIDTH/8-1:0]   WSTRB,
   output logic                      WLAST,
   input  logic                      BVALID,
   input  logic [1:0]                BRESP,
   output logic                      BREADY
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int SIZE  = $clog2(BYTES);
   localparam int BW    = 9;
   localparam int CW    = LEN_WIDTH + BW;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ADDR = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_RESP = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   logic [2:0]            state_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [LEN_WIDTH-1:0]  rem_r;
   logic [BW-1:0]         beat_r;
   logic                  err_r;
   logic [BW-1:0]         cap_s;
   logic [BW-1:0]         burst_s;
   logic                  last_s;
   logic                  w_hs_s;
   logic                  slv_err_s;
`ifdef AXI_WR_4K_SPLIT_EN
   logic [12:0]           page_beats_s;
`endif

   // Beats in the current burst: remaining work capped by MAX_BURST (and the 4 KB page when enabled).
   always_comb begin
      cap_s = (CW'(rem_r) < CW'(MAX_BURST)) ? BW'(rem_r) : BW'(MAX_BURST);
`ifdef AXI_WR_4K_SPLIT_EN
      page_beats_s = (13'h1000 - {1'b0, addr_r[11:0]}) >> SIZE;
      burst_s      = (page_beats_s < 13'(cap_s)) ? BW'(page_beats_s) : cap_s;
`else
      burst_s      = cap_s;
`endif
   end

   assign last_s    = (beat_r == (burst_s - 9'd1));
   assign w_hs_s    = WVALID && WREADY;
   assign slv_err_s = (BRESP == 2'b10) || (BRESP == 2'b11);

   // Channel outputs decoded from the state register; everything idles at zero outside its owning state.
   always_comb begin
      busy       = (state_r != ST_IDLE);
      done       = (state_r == ST_DONE);
      err        = err_r;
      AWVALID    = (state_r == ST_ADDR);
      AWADDR     = AWVALID ? addr_r : {ADDR_WIDTH{1'b0}};
      AWLEN      = AWVALID ? 8'(burst_s - 9'd1) : 8'd0;
      AWSIZE     = AWVALID ? 3'(SIZE) : 3'd0;
      AWBURST    = AWVALID ? 2'b01 : 2'b00;
      WVALID     = (state_r == ST_DATA) && !fifo_rempty;
      WDATA      = (state_r == ST_DATA) ? fifo_rdata : {DATA_WIDTH{1'b0}};
      WSTRB      = (state_r == ST_DATA) ? {(DATA_WIDTH/8){1'b1}} : {(DATA_WIDTH/8){1'b0}};
      WLAST      = WVALID && last_s;
      fifo_rpull = w_hs_s;
      BREADY     = (state_r == ST_RESP);
   end

   // Transfer sequencer: one AW open at a time, slave errors are sticky but never abort.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         addr_r  <= {ADDR_WIDTH{1'b0}};
         rem_r   <= {LEN_WIDTH{1'b0}};
         beat_r  <= 9'd0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  addr_r  <= target_addr;
                  rem_r   <= target_beats;
                  beat_r  <= 9'd0;
                  err_r   <= 1'b0;
                  state_r <= (target_beats == {LEN_WIDTH{1'b0}}) ? ST_DONE : ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (AWREADY) begin
                  beat_r  <= 9'd0;
                  state_r <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_hs_s) begin
                  if (last_s) begin
                     beat_r  <= 9'd0;
                     state_r <= ST_RESP;
                  end else begin
                     beat_r  <= beat_r + 9'd1;
                  end
               end
            end
            ST_RESP: begin
               if (BVALID) begin
                  err_r   <= err_r | slv_err_s;
                  addr_r  <= addr_r + (ADDR_WIDTH'(burst_s) << SIZE);
                  rem_r   <= rem_r - LEN_WIDTH'(burst_s);
                  state_r <= (rem_r == LEN_WIDTH'(burst_s)) ? ST_DONE : ST_ADDR;
               end
            end
            ST_DONE: begin
               if (done_ack) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_master_burst_writer.sv
// Scoreboard bench for axi_master_burst_writer: expected AW/W/done results are queued by the
// stimulus and popped by an independent monitor at each handshake.
module tb_axi_master_burst_writer;
   logic        clk = 1'b0;
   logic        rst, start, done_ack;
   logic [31:0] target_addr;
   logic [15:0] target_beats;
   logic        busy, done, err;
   logic [31:0] fifo_rdata;
   logic        fifo_rempty, fifo_rpull;
   logic        AWREADY, AWVALID;
   logic [31:0] AWADDR;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        WREADY, WVALID, WLAST;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        BVALID, BREADY;
   logic [1:0]  BRESP;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [39:0] aw_q[$];
   logic [32:0] w_q[$];
   logic        err_q[$];
   logic [31:0] bslave_q[$];
   logic [31:0] last_aw_addr = 32'd0;
   logic [31:0] err_addr     = 32'hFFFF_FFFF;
   logic [31:0] pull_cnt     = 32'd0;
   logic [31:0] exp_word     = 32'd0;
   bit          ignore_mon = 1'b0, wr_toggle = 1'b0, empty_gap = 1'b0, aw_slow = 1'b0;

   always #5 clk = ~clk;
   assign fifo_rdata = 32'hD000_0000 + pull_cnt;

   axi_master_burst_writer dut (
      .clk(clk), .rst(rst), .start(start), .target_addr(target_addr), .target_beats(target_beats),
      .busy(busy), .done(done), .err(err), .done_ack(done_ack),
      .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rpull(fifo_rpull),
      .AWREADY(AWREADY), .AWVALID(AWVALID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .WREADY(WREADY), .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB),
      .WLAST(WLAST), .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_burst(input logic [31:0] a, input logic [7:0] len);
      aw_q.push_back({a, len});
      for (int i = 0; i <= int'(len); i++) begin
         w_q.push_back({(i == int'(len)), 32'hD000_0000 + exp_word});
         exp_word++;
      end
   endtask

   task automatic run(input logic [31:0] a, input logic [15:0] n, input logic exp_err, input bit poke);
      int k;
      err_q.push_back(exp_err);
      @(negedge clk);
      target_addr = a; target_beats = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0; target_addr = 32'hDEAD_0000; target_beats = 16'd3;
      if (poke) begin
         repeat (3) @(negedge clk);
         start = 1'b1; done_ack = 1'b1;
         @(negedge clk);
         start = 1'b0; done_ack = 1'b0;
      end
      k = 0;
      while (!done && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("done_reached", done, 1'b1);
      repeat (3) @(negedge clk);
      chk("done_held", {done, busy, err}, {1'b1, 1'b1, exp_err});
      done_ack = 1'b1;
      @(negedge clk);
      done_ack = 1'b0;
      chk("idle_after_ack", {done, busy}, 2'b00);
   endtask

   // Slave/FIFO input driver: updates on the falling edge.
   initial begin : drv
      int cyc;
      cyc = 0;
      AWREADY = 1'b0; WREADY = 1'b0; fifo_rempty = 1'b1; BVALID = 1'b0; BRESP = 2'b00;
      forever begin
         @(negedge clk);
         cyc++;
         AWREADY     = aw_slow ? (cyc % 4 == 0) : 1'b1;
         WREADY      = wr_toggle ? cyc[0] : 1'b1;
         fifo_rempty = empty_gap && (cyc % 10 >= 3) && (cyc % 10 <= 5);
         BVALID      = (bslave_q.size() > 0);
         if (BVALID && bslave_q[0] == err_addr) BRESP = 2'b10;
         else BRESP = 2'b00;
      end
   end

   // Monitor: samples 1 time unit before each rising edge, then updates slave/FIFO state after it.
   initial begin : mon
      logic aw_hs, w_hs, wl_hs, b_hs, pull, done_prev, aw_hold;
      logic [39:0] hold_aw, e_aw;
      logic [32:0] e_w;
      done_prev = 1'b0; aw_hold = 1'b0; hold_aw = 40'd0;
      forever begin
         @(negedge clk);
         #4;
         aw_hs = AWVALID && AWREADY;
         w_hs  = WVALID && WREADY;
         wl_hs = w_hs && WLAST;
         b_hs  = BVALID && BREADY;
         pull  = fifo_rpull;
         chk("one_channel", ($countones({AWVALID, WVALID, BREADY}) > 1), 1'b0);
         chk("rpull_eq_whs", fifo_rpull, w_hs);
         chk("wlast_needs_wvalid", WLAST && !WVALID, 1'b0);
         if (fifo_rempty) chk("wvalid_when_empty", {WVALID, fifo_rpull}, 2'b00);
         if (aw_hold) chk("aw_stable", {AWVALID, AWADDR, AWLEN}, {1'b1, hold_aw});
         aw_hold = AWVALID && !AWREADY && !rst;
         hold_aw = {AWADDR, AWLEN};
         if (!ignore_mon) begin
            if (aw_hs) begin
               if (aw_q.size() == 0) chk("aw_unexpected", {AWADDR, AWLEN}, 40'd0 - 40'd1);
               else begin
                  e_aw = aw_q.pop_front();
                  chk("aw_addr_len", {AWADDR, AWLEN}, e_aw);
                  chk("aw_size_burst", {AWSIZE, AWBURST}, {3'd2, 2'd1});
               end
            end
            if (w_hs) begin
               if (w_q.size() == 0) chk("w_unexpected", {WLAST, WDATA}, 33'd0 - 33'd1);
               else begin
                  e_w = w_q.pop_front();
                  chk("w_beat", {WLAST, WDATA}, e_w);
                  chk("w_strb", WSTRB, 4'hF);
               end
            end
            if (done && !done_prev) begin
               if (err_q.size() == 0) chk("done_unexpected", done, 1'b0);
               else chk("err_at_done", err, err_q.pop_front());
            end
         end
         if (aw_hs) last_aw_addr = AWADDR;
         done_prev = done;
         @(posedge clk);
         #1;
         if (pull) pull_cnt++;
         if (wl_hs) bslave_q.push_back(last_aw_addr);
         if (b_hs && bslave_q.size() > 0) void'(bslave_q.pop_front());
      end
   end

   initial begin : stim
      int k;
      rst = 1'b1; start = 1'b0; done_ack = 1'b0; target_addr = 32'd0; target_beats = 16'd0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {AWVALID, WVALID, WLAST, BREADY, fifo_rpull, done, busy, err}, 8'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outputs", {AWVALID, WVALID, BREADY, done, busy}, 5'd0);

      // Single 8-beat burst
      expect_burst(32'h0000_1000, 8'd7);
      run(32'h0000_1000, 16'd8, 1'b0, 1'b0);

      // 40 beats split 16/16/8; start and done_ack pokes mid-transfer must be ignored
      expect_burst(32'h0000_0000, 8'd15);
      expect_burst(32'h0000_0040, 8'd15);
      expect_burst(32'h0000_0080, 8'd7);
      run(32'h0000_0000, 16'd40, 1'b0, 1'b1);

      // Burst straddling a 4 KB page
`ifdef AXI_WR_4K_SPLIT_EN
      expect_burst(32'h0000_0FF8, 8'd1);
      expect_burst(32'h0000_1000, 8'd5);
`else
      expect_burst(32'h0000_0FF8, 8'd7);
`endif
      run(32'h0000_0FF8, 16'd8, 1'b0, 1'b0);

      // FIFO gaps, WREADY toggling and slow AWREADY
      empty_gap = 1'b1; wr_toggle = 1'b1; aw_slow = 1'b1;
      expect_burst(32'h0000_5000, 8'd15);
      expect_burst(32'h0000_5040, 8'd3);
      run(32'h0000_5000, 16'd20, 1'b0, 1'b0);
      empty_gap = 1'b0; wr_toggle = 1'b0; aw_slow = 1'b0;

      // Slave error on the second burst: transfer completes, err sticky until ack
      err_addr = 32'h0000_0040;
      expect_burst(32'h0000_0000, 8'd15);
      expect_burst(32'h0000_0040, 8'd15);
      expect_burst(32'h0000_0080, 8'd15);
      run(32'h0000_0000, 16'd48, 1'b1, 1'b0);
      err_addr = 32'hFFFF_FFFF;

      // Zero-beat request goes straight to done and clears the previous err
      run(32'h0000_3000, 16'd0, 1'b0, 1'b0);

      // Reset in the middle of a data phase
      ignore_mon = 1'b1; wr_toggle = 1'b1;
      @(negedge clk);
      target_addr = 32'h0000_6000; target_beats = 16'd16; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!WVALID && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("reach_data", WVALID, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("reset_mid_burst", {AWVALID, WVALID, WLAST, BREADY, fifo_rpull, done, busy}, 7'd0);
      repeat (2) @(negedge clk);
      chk("no_stale_b", bslave_q.size(), 0);
      exp_word = pull_cnt;
      wr_toggle = 1'b0; ignore_mon = 1'b0;
      expect_burst(32'h0000_2000, 8'd3);
      run(32'h0000_2000, 16'd4, 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      chk("aw_queue_drained", aw_q.size(), 0);
      chk("w_queue_drained", w_q.size(), 0);
      chk("done_queue_drained", err_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/axi_master_burst_writer.md
AXI_MASTER_BURST_WRITER -- requirements
Module: axi_master_burst_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, W data width (power of two, 8..1024).
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the total-beat request count.
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum beats per AXI burst (power of two, 1..256).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports start (in, 1), target_addr (in, ADDR_WIDTH) and target_beats (in, LEN_WIDTH), the transfer request.
REQ-008 SHALL have ports busy (out, 1), done (out, 1), err (out, 1) and done_ack (in, 1), the status handshake.
REQ-009 SHALL have ports fifo_rdata (in, DATA_WIDTH) and fifo_rempty (in, 1) from a first-word-fall-through source FIFO, plus fifo_rpull (out, 1).
REQ-010 SHALL have AW ports AWREADY in 1, AWVALID out 1, AWADDR out ADDR_WIDTH, AWLEN out 8, AWSIZE out 3 and AWBURST out 2.
REQ-011 SHALL have W ports WREADY in 1, WVALID out 1, WDATA out DATA_WIDTH, WSTRB out DATA_WIDTH/8 and WLAST out 1.
REQ-012 SHALL have B ports BVALID in 1, BRESP in 2 and BREADY out 1.

Function
REQ-013 SHALL implement states IDLE, ADDR, DATA, RESP and DONE, with busy = (state != IDLE).
REQ-014 In IDLE with start=1, SHALL latch target_addr and target_beats, clear err and go to ADDR; if target_beats=0 it SHALL go directly to DONE; start SHALL be ignored in all other states.
REQ-015 Burst size SHALL be burst_beats = min(remaining, MAX_BURST), further limited per REQ-028.
REQ-016 In ADDR, SHALL drive AWVALID=1, AWLEN=burst_beats-1, AWSIZE=log2(DATA_WIDTH/8) and AWBURST=2'b01 (INCR), holding all AW signals stable until AWVALID&&AWREADY, then go to DATA.
REQ-017 In DATA, SHALL drive WVALID = !fifo_rempty, WDATA = fifo_rdata and WSTRB all ones.
REQ-018 fifo_rpull SHALL equal WVALID&&WREADY; the beat counter SHALL increment only on that handshake.
REQ-019 WLAST SHALL be 1 only while WVALID=1 and the beat counter = burst_beats-1; on that handshake the block SHALL go to RESP.
REQ-020 In RESP, SHALL drive BREADY=1; on BVALID it SHALL set err if BRESP[1]=1 (sticky) and update addr += burst_beats*(DATA_WIDTH/8) (modulo 2^ADDR_WIDTH) and remaining -= burst_beats.
REQ-021 After RESP, SHALL go to ADDR if remaining != 0, else to DONE.
REQ-022 A slave error SHALL NOT abort the transfer; all requested beats SHALL be written and the FIFO drained.
REQ-023 In DONE, SHALL drive done=1 and hold err until done_ack=1, then go to IDLE; done_ack outside DONE SHALL have no effect.
REQ-024 AWVALID, WVALID and BREADY SHALL never be asserted in the same cycle; exactly one AW transaction SHALL be open at a time.
REQ-025 When not in its owning state, each valid/ready output SHALL be 0, and WDATA/WSTRB SHALL be 0 outside DATA.

Reset
REQ-026 With rst=1 at a clock edge, the block SHALL enter IDLE and clear counters, addr, remaining and err; AWVALID, WVALID, WLAST, BREADY, fifo_rpull, done and busy SHALL be 0 in the following cycle, including mid-burst.
REQ-027 After a mid-operation reset, the block SHALL accept a new start with no residual state.

Configuration
REQ-028 With macro AXI_WR_4K_SPLIT_EN defined, burst_beats SHALL additionally be limited to the number of beats remaining before the next 4 KB address boundary, so no burst crosses 4 KB; without the macro, no boundary limit SHALL be applied.

Verification
REQ-029 addr=0x1000, beats=8, AWREADY/WREADY always 1, FIFO non-empty -> one AW with AWLEN=7, AWSIZE=2, AWBURST=1; 8 W beats, WLAST on the 8th; BRESP=0 -> done=1, err=0.
REQ-030 addr=0x0, beats=40, MAX_BURST=16 -> three bursts AWADDR 0x0/0x40/0x80 with AWLEN 15/15/7, each followed by BREADY; then done.
REQ-031 addr=0x0FF8, beats=8, DATA_WIDTH=32 -> with AXI_WR_4K_SPLIT_EN: AWLEN=1 at 0xFF8, then AWLEN=5 at 0x1000; without the macro: a single AWLEN=7 at 0xFF8.
REQ-032 FIFO empty for 3 cycles mid-burst and WREADY toggling -> WVALID=0 and fifo_rpull=0 while empty; no beat lost or duplicated; WLAST only on the final beat.
REQ-033 beats=48 with BRESP=2'b10 on burst 2 -> all 3 bursts complete, err=1 at done, held until done_ack, then busy=0.
REQ-034 rst pulsed during DATA -> next cycle all valid/ready/done/busy outputs are 0; a following start at addr=0x2000, beats=4 completes normally.
